// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Purpose  : Requester-side bundle for alu_arbiter. Carries two packed
//             request lanes (req0 in the low slice, req1 in the high slice),
//             the accept strobes and the registered response back.
//  Modports : master - requester side (drives req_*, rsp_ready)
//             slave  - arbiter side   (drives req_ready, rsp_*)
//  Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DW  = 32,
    parameter int OPW = 4
);
    logic [1:0]       req_valid;
    logic [2*OPW-1:0] req_aluop;
    logic [2*DW-1:0]  req_porta;
    logic [2*DW-1:0]  req_portb;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [DW-1:0]    rsp_out;
    logic             rsp_zero;
    logic             rsp_over;
    logic             rsp_neg;

    modport master (
        output req_valid, req_aluop, req_porta, req_portb, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_zero, rsp_over, rsp_neg
    );

    modport slave (
        input  req_valid, req_aluop, req_porta, req_portb, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_zero, rsp_over, rsp_neg
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one external combinational ALU between two requesters.
//             Round-robin grant, valid/ready handshake, operands latched at
//             accept and result/flags registered after one EXEC cycle.
//  Ports    : CLK, RST          clock, synchronous active-high reset
//             req_bus (slave)   request/response bundle, see alu_arbiter_if
//             alu_aluop/porta/portb  latched operands to the ALU
//             alu_outport/zero/over/neg  ALU result, captured bit-exact
//  Options  : ALU_ARB_STATS_EN  adds grant_cnt0, grant_cnt1, stall_cnt
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    alu_arbiter_if.slave        req_bus,
    output logic [OPW-1:0]      alu_aluop,
    output logic [DW-1:0]       alu_porta,
    output logic [DW-1:0]       alu_portb,
    input  wire logic [DW-1:0]  alu_outport,
    input  wire logic           alu_zero,
    input  wire logic           alu_over,
    input  wire logic           alu_neg
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]         grant_cnt0,
    output logic [31:0]         grant_cnt1,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_owner;
    logic            r_last_grant;
    logic [OPW-1:0]  r_aluop;
    logic [DW-1:0]   r_porta;
    logic [DW-1:0]   r_portb;
    logic [DW-1:0]   r_rsp_out;
    logic            r_rsp_zero;
    logic            r_rsp_over;
    logic            r_rsp_neg;

    logic [1:0]      w_grant;
    logic            w_win;
    logic            w_accept;
    logic [1:0]      w_req_ready;
    logic [1:0]      w_rsp_valid;
    logic            w_owner_ready;

    // Round-robin: a tie goes to the requester that was not served last.
    always_comb begin
        w_grant = 2'b00;
        case (req_bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_win         = w_grant[1];
    assign w_owner_ready = r_owner ? req_bus.rsp_ready[1] : req_bus.rsp_ready[0];

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_req_ready  = 2'b00;
        w_rsp_valid  = 2'b00;
        case (r_state)
            S_IDLE: begin
                // ready mirrors the grant, so any grant is a completed handshake
                w_req_ready = w_grant;
                if (w_grant != 2'b00) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = r_owner ? 2'b10 : 2'b01;
                if (w_owner_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_aluop      <= '0;
            r_porta      <= '0;
            r_portb      <= '0;
            r_rsp_out    <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_over   <= 1'b0;
            r_rsp_neg    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_win;
                r_last_grant <= w_win;
                r_aluop      <= w_win ? req_bus.req_aluop[2*OPW-1:OPW] : req_bus.req_aluop[OPW-1:0];
                r_porta      <= w_win ? req_bus.req_porta[2*DW-1:DW]   : req_bus.req_porta[DW-1:0];
                r_portb      <= w_win ? req_bus.req_portb[2*DW-1:DW]   : req_bus.req_portb[DW-1:0];
            end
            if (r_state == S_EXEC) begin
                r_rsp_out  <= alu_outport;
                r_rsp_zero <= alu_zero;
                r_rsp_over <= alu_over;
                r_rsp_neg  <= alu_neg;
            end
        end
    end

    // The operand latch feeds the ALU directly, so alu_* only move on accept.
    assign alu_aluop         = r_aluop;
    assign alu_porta         = r_porta;
    assign alu_portb         = r_portb;
    assign req_bus.req_ready = w_req_ready;
    assign req_bus.rsp_valid = w_rsp_valid;
    assign req_bus.rsp_out   = r_rsp_out;
    assign req_bus.rsp_zero  = r_rsp_zero;
    assign req_bus.rsp_over  = r_rsp_over;
    assign req_bus.rsp_neg   = r_rsp_neg;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    // The IDLE term cannot fire with the grant rules above; it is kept so a
    // future grant policy change still shows up as a stall.
    assign w_stall = ((r_state == S_IDLE) && (req_bus.req_valid != 2'b00) && !w_accept) ||
                     ((r_state == S_RESP) && !w_owner_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_accept && !w_win) begin
                r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_accept && w_win) begin
                r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. A transaction-level model
//             (in-flight op with an age count, served-last memory) predicts
//             every output each cycle; directed scenarios add literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd3;

    logic clk;
    logic rst;

    logic [OPW-1:0] alu_aluop;
    logic [DW-1:0]  alu_porta;
    logic [DW-1:0]  alu_portb;
    logic [DW-1:0]  alu_outport;
    logic           alu_zero;
    logic           alu_over;
    logic           alu_neg;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]    grant_cnt0;
    logic [31:0]    grant_cnt1;
    logic [31:0]    stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .CLK         (clk),
        .RST         (rst),
        .req_bus     (bus.slave),
        .alu_aluop   (alu_aluop),
        .alu_porta   (alu_porta),
        .alu_portb   (alu_portb),
        .alu_outport (alu_outport),
        .alu_zero    (alu_zero),
        .alu_over    (alu_over),
        .alu_neg     (alu_neg)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1),
        .stall_cnt   (stall_cnt)
`endif
    );

    // Reference ALU: returns {over, neg, zero, out}
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (op)
            4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {ov, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_over, alu_neg, alu_zero, alu_outport} = alu_fn(alu_aluop, alu_porta, alu_portb);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    bit          m_init = 1'b0;
    bit          m_busy;
    int          m_age;
    int          m_owner;
    int          m_last;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [34:0] m_pending;
    logic [34:0] m_res;
    logic [31:0] m_gc0, m_gc1, m_stall;

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return -1;
    endfunction

    initial begin : model_and_compare
        int          w;
        logic [1:0]  exp_rdy, exp_rv;
        forever begin
            @(negedge clk);
            if (m_init) begin
                w       = m_busy ? -1 : pick(bus.req_valid, m_last);
                exp_rdy = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
                exp_rv  = (m_busy && m_age >= 2) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
                chk("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
                chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, exp_rv});
                chk("rsp_out",   bus.rsp_out, m_res[31:0]);
                chk("rsp_flags", {29'd0, bus.rsp_over, bus.rsp_neg, bus.rsp_zero}, {29'd0, m_res[34:32]});
                chk("alu_aluop", {28'd0, alu_aluop}, {28'd0, m_op});
                chk("alu_porta", alu_porta, m_a);
                chk("alu_portb", alu_portb, m_b);
`ifdef ALU_ARB_STATS_EN
                chk("grant_cnt0", grant_cnt0, m_gc0);
                chk("grant_cnt1", grant_cnt1, m_gc1);
                chk("stall_cnt",  stall_cnt,  m_stall);
`endif
            end
            // advance the model across the coming rising edge
            if (rst) begin
                m_init  = 1'b1;
                m_busy  = 1'b0;
                m_age   = 0;
                m_owner = 0;
                m_last  = 1;
                m_op    = '0;
                m_a     = '0;
                m_b     = '0;
                m_res   = '0;
                m_gc0   = '0;
                m_gc1   = '0;
                m_stall = '0;
            end else if (m_init) begin
                if (!m_busy) begin
                    w = pick(bus.req_valid, m_last);
                    if (w >= 0) begin
                        m_op      = bus.req_aluop[w*OPW +: OPW];
                        m_a       = bus.req_porta[w*DW +: DW];
                        m_b       = bus.req_portb[w*DW +: DW];
                        m_pending = alu_fn(m_op, m_a, m_b);
                        m_owner   = w;
                        m_last    = w;
                        m_busy    = 1'b1;
                        m_age     = 1;
                        if (w == 0) m_gc0 = m_gc0 + 32'd1;
                        else        m_gc1 = m_gc1 + 32'd1;
                    end
                end else if (m_age == 1) begin
                    m_res = m_pending;
                    m_age = 2;
                end else begin
                    if (bus.rsp_ready[m_owner]) m_busy = 1'b0;
                    else                        m_stall = m_stall + 32'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change just after the rising edge; literal checks
    // run just after the falling edge of the same cycle.
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic [1:0] v,
                        input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic [1:0] rr);
        @(posedge clk);
        #1;
        rst           = r;
        bus.req_valid = v;
        bus.req_aluop = {o1, o0};
        bus.req_porta = {a1, a0};
        bus.req_portb = {b1, b0};
        bus.rsp_ready = rr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input logic [1:0] rr);
        step(r, 2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, rr);
    endtask

    initial begin : stimulus
        logic [1:0]  grants[$];
        int          rsp_seen;
        logic [31:0] held_out;
        logic [31:0] ra0, ra1, rb0, rb1;

        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_aluop = '0;
        bus.req_porta = '0;
        bus.req_portb = '0;
        bus.rsp_ready = 2'b00;

        idle(1'b1, 2'b00);
        idle(1'b1, 2'b00);
        chk("reset rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("reset rsp_out",   bus.rsp_out, 32'd0);
        chk("reset alu_porta", alu_porta, 32'd0);

        // single request from req0: ADD 5+7
        step(1'b0, 2'b01, OP_ADD, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 2'b00);
        chk("add accept ready", {30'd0, bus.req_ready}, 32'd1);
        idle(1'b0, 2'b00);
        chk("add exec porta", alu_porta, 32'd5);
        chk("add exec rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        idle(1'b0, 2'b01);
        chk("add rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("add rsp_out",   bus.rsp_out, 32'd12);
        chk("add rsp_zero",  {31'd0, bus.rsp_zero}, 32'd0);
        idle(1'b0, 2'b00);

        // both valid from reset: alternating grants, first tie to req0
        idle(1'b1, 2'b00);
        rsp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 2'b11, OP_SUB, 32'd3, 32'd3, OP_OR, 32'h0000_00F0, 32'h0000_000F, 2'b11);
            if (bus.req_ready != 2'b00) grants.push_back(bus.req_ready);
            if (bus.rsp_valid != 2'b00) begin
                if (rsp_seen == 0) begin
                    chk("tie first rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
                    chk("sub rsp_out", bus.rsp_out, 32'd0);
                    chk("sub rsp_zero", {31'd0, bus.rsp_zero}, 32'd1);
                end else if (rsp_seen == 1) begin
                    chk("tie second rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
                    chk("or rsp_out", bus.rsp_out, 32'h0000_00FF);
                end
                rsp_seen++;
            end
        end
        chk("tie grant count", grants.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("tie grant order", (i < grants.size()) ? {30'd0, grants[i]} : 32'd0,
                (i % 2 == 0) ? 32'd1 : 32'd2);
        end
`ifdef ALU_ARB_STATS_EN
        chk("stats gc0", grant_cnt0, 32'd2);
        chk("stats gc1", grant_cnt1, 32'd2);
`endif

        // overflow on req1, then owner back-pressure with non-owner ready
        step(1'b0, 2'b10, 4'd0, 32'd0, 32'd0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 2'b00);
        chk("ovf accept ready", {30'd0, bus.req_ready}, 32'd2);
        idle(1'b0, 2'b00);
        idle(1'b0, 2'b00);
        chk("ovf rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
        chk("ovf rsp_out",   bus.rsp_out, 32'h8000_0000);
        chk("ovf over",      {31'd0, bus.rsp_over}, 32'd1);
        chk("ovf neg",       {31'd0, bus.rsp_neg}, 32'd1);
        held_out = bus.rsp_out;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b01, OP_ADD, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 2'b01);
            chk("hold rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
            chk("hold rsp_out",   bus.rsp_out, held_out);
            chk("hold req_ready", {30'd0, bus.req_ready}, 32'd0);
        end
        idle(1'b0, 2'b10);
        idle(1'b0, 2'b00);
        chk("release rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);

        // reset while in EXEC
        step(1'b0, 2'b01, OP_ADD, 32'd9, 32'd9, 4'd0, 32'd0, 32'd0, 2'b00);
        chk("rst-exec accept", {30'd0, bus.req_ready}, 32'd1);
        idle(1'b1, 2'b00);
        chk("rst-exec porta", alu_porta, 32'd9);
        step(1'b0, 2'b11, OP_SUB, 32'd4, 32'd1, OP_SUB, 32'd8, 32'd2, 2'b00);
        chk("post-rst rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("post-rst alu_porta", alu_porta, 32'd0);
        chk("post-rst tie grant", {30'd0, bus.req_ready}, 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            ra0 = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            ra1 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            rb1 = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
            step(($urandom_range(0, 99) == 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 5)), ra0, rb0,
                 4'($urandom_range(0, 5)), ra1, rb1,
                 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
